// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared constants and state encoding for the fetch stage
package ifetch_unit_pkg;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_BASE = 32'h0000_0000;
  typedef enum logic [1:0] {IF_REQ, IF_WAIT, IF_HOLD, IF_DISCARD} if_state_e;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction memory request/response handshake
interface ifetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ifetch_unit_perf_cnt.sv
// ifetch_perf_cnt: delivery and stall-cycle counters, wrapping at 2^32
module ifetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (fetch ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding fetch stage loading the IF/ID register.
// Defining IFETCH_PERF_EN adds perf_fetch_cnt/perf_stall_cnt outputs.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               stallD,
  input  logic               flushD,
  output logic               stallF,
  ifetch_unit_if.master      imem,
  output logic [DATA_W-1:0]  instrD,
  output logic [ADDR_W-1:0]  pcD,
  output logic               validD
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d, pcd_q, pcd_d;
  logic [DATA_W-1:0] buf_q, buf_d, instr_q, instr_d;
  logic              valid_q, valid_d, accept, deliver, rsp_in_wait;
  assign imem.req_valid = !rst && state_q == IF_REQ;
  assign imem.req_addr = pc;
  always_comb begin
    accept = imem.req_valid && imem.req_ready;
    rsp_in_wait = state_q == IF_WAIT && imem.rsp_valid;
    deliver = !flushD && !stallD && (rsp_in_wait || state_q == IF_HOLD);
    stallF = rst || !(flushD || deliver);
    req_pc_d = accept ? pc : req_pc_q;
    buf_d = rsp_in_wait ? imem.rsp_data : buf_q;
    state_d = state_q;
    case (state_q)
      IF_REQ:  state_d = accept ? (flushD ? IF_DISCARD : IF_WAIT) : IF_REQ;
      IF_WAIT: state_d = imem.rsp_valid ? ((stallD && !flushD) ? IF_HOLD : IF_REQ)
                                        : (flushD ? IF_DISCARD : IF_WAIT);
      IF_HOLD: state_d = (flushD || !stallD) ? IF_REQ : IF_HOLD;
      default: state_d = imem.rsp_valid ? IF_REQ : IF_DISCARD;
    endcase
    // flush beats delivery; a stalled decode keeps its live instruction
    instr_d = flushD ? NOP_INSTR : deliver ? (state_q == IF_HOLD ? buf_q : imem.rsp_data) : instr_q;
    pcd_d = deliver ? req_pc_q : pcd_q;
    valid_d = deliver || (stallD && !flushD && valid_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IF_REQ;
      req_pc_q <= '0;
      buf_q    <= '0;
      instr_q  <= NOP_INSTR;
      pcd_q    <= ADDR_W'(PC_BASE);
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      valid_q  <= valid_d;
    end
  end
  assign instrD = instr_q;
  assign pcD = pcd_q;
  assign validD = valid_q;
`ifdef IFETCH_PERF_EN
  ifetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch     (deliver && !rst),
    .stall     (stallF && !rst),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif
endmodule
